// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared encodings for the IFU/LSU memory arbiter.
//   ST_*       one-hot FSM state encoding (3 bits)
//   OWN_*      requester encoding, also used for last_grant
//   TIMEOUT_DEF default response timeout in cycles
package mem_arb_pkg;

  localparam logic [2:0] ST_IDLE = 3'b001;
  localparam logic [2:0] ST_REQ  = 3'b010;
  localparam logic [2:0] ST_RESP = 3'b100;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin grant.
//   req_i[0]     IFU request, req_i[1] LSU request
//   last_grant_i requester granted most recently (OWN_IFU / OWN_LSU)
//   grant_o      one-hot grant; zero when nobody requests
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  // A lone requester always wins; on contention the one not served last wins.
  assign grant_o[0] = req_i[0] & (~req_i[1] | (last_grant_i == OWN_LSU));
  assign grant_o[1] = req_i[1] & (~req_i[0] | (last_grant_i == OWN_IFU));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the IFU and the LSU with a
// single outstanding transaction, round-robin arbitration and a response
// timeout.
//   clk / rst           clock, asynchronous active-low reset
//   ifu_req_* / ifu_addr           IFU read request, ready is combinational
//   ifu_resp_*                     IFU response pulse, data, timeout flag
//   lsu_req_* / lsu_addr/wen/wdata/wmask   LSU request
//   lsu_resp_*                     LSU response pulse, data, timeout flag
//   mem_req_* / mem_addr/wen/wdata/wmask   registered request to memory
//   mem_resp_valid / mem_resp_data         memory response
//
// state   | meaning
// IDLE    | waiting for a request; ready asserted for the round-robin winner
// REQ     | presenting the latched payload until memory accepts it
// RESP    | waiting for the memory response, counting toward the timeout
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_resp_data,
  output logic                ifu_resp_err,

  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_resp_data,
  output logic                lsu_resp_err,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wmask_q, wmask_d;

  logic              ifu_rvalid_q, ifu_rvalid_d;
  logic [DATA_W-1:0] ifu_rdata_q, ifu_rdata_d;
  logic              ifu_rerr_q, ifu_rerr_d;
  logic              lsu_rvalid_q, lsu_rvalid_d;
  logic [DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;
  logic              lsu_rerr_q, lsu_rerr_d;

  logic [1:0]        grant;
  logic              idle;
  logic              resp_done;
  logic              resp_err;
  logic [DATA_W-1:0] resp_data;

  rr_arb2 u_rr_arb2 (
    .req_i        ({lsu_req_valid, ifu_req_valid}),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  // Ready is combinational; gating with rst keeps it low while reset is held.
  assign idle          = (state_q == ST_IDLE) & rst;
  assign ifu_req_ready = idle & grant[0];
  assign lsu_req_ready = idle & grant[1];

  assign mem_req_valid = (state_q == ST_REQ);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;

  assign ifu_resp_valid = ifu_rvalid_q;
  assign ifu_resp_data  = ifu_rdata_q;
  assign ifu_resp_err   = ifu_rerr_q;
  assign lsu_resp_valid = lsu_rvalid_q;
  assign lsu_resp_data  = lsu_rdata_q;
  assign lsu_resp_err   = lsu_rerr_q;

  // A real response beats a coincident timeout; writes return zero data.
  always_comb begin
    resp_done = 1'b0;
    resp_err  = 1'b0;
    resp_data = '0;
    if (state_q == ST_RESP) begin
      if (mem_resp_valid) begin
        resp_done = 1'b1;
        resp_data = wen_q ? '0 : mem_resp_data;
      end else if (cnt_q == CNT_LAST) begin
        resp_done = 1'b1;
        resp_err  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    ifu_rvalid_d = 1'b0;
    ifu_rdata_d  = ifu_rdata_q;
    ifu_rerr_d   = ifu_rerr_q;
    lsu_rvalid_d = 1'b0;
    lsu_rdata_d  = lsu_rdata_q;
    lsu_rerr_d   = lsu_rerr_q;

    case (state_q)
      ST_IDLE: begin
        if (lsu_req_ready) begin
          owner_d      = OWN_LSU;
          last_grant_d = OWN_LSU;
          addr_d       = lsu_addr;
          wen_d        = lsu_wen;
          wdata_d      = lsu_wdata;
          wmask_d      = lsu_wmask;
          state_d      = ST_REQ;
        end else if (ifu_req_ready) begin
          owner_d      = OWN_IFU;
          last_grant_d = OWN_IFU;
          addr_d       = ifu_addr;
          wen_d        = 1'b0;
          wdata_d      = '0;
          wmask_d      = '0;
          state_d      = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          state_d = ST_RESP;
          cnt_d   = '0;
        end
      end
      ST_RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (resp_done) begin
          state_d = ST_IDLE;
          if (owner_q == OWN_LSU) begin
            lsu_rvalid_d = 1'b1;
            lsu_rdata_d  = resp_data;
            lsu_rerr_d   = resp_err;
          end else begin
            ifu_rvalid_d = 1'b1;
            ifu_rdata_d  = resp_data;
            ifu_rerr_d   = resp_err;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_IFU;
      last_grant_q <= OWN_LSU;
      cnt_q        <= '0;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      ifu_rvalid_q <= 1'b0;
      ifu_rdata_q  <= '0;
      ifu_rerr_q   <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      lsu_rdata_q  <= '0;
      lsu_rerr_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      ifu_rvalid_q <= ifu_rvalid_d;
      ifu_rdata_q  <= ifu_rdata_d;
      ifu_rerr_q   <= ifu_rerr_d;
      lsu_rvalid_q <= lsu_rvalid_d;
      lsu_rdata_q  <= lsu_rdata_d;
      lsu_rerr_q   <= lsu_rerr_d;
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single instruction/data memory port between the instruction fetch unit (IFU) and the load/store unit (LSU) of the multi-cycle core. It accepts at most one outstanding transaction, forwards it to the memory port, and routes the response back to the requester that issued it. Arbitration is round-robin, and a response timeout guards against a hung memory.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width. `DATA_W/8` is the strobe width.
- `TIMEOUT`, 255: maximum number of cycles spent waiting for a memory response. Must be at least 1.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ifu_req_valid`  in  1  IFU read request.
- `ifu_req_ready`  out  1  IFU request accepted this cycle.
- `ifu_addr`  in  ADDR_W  IFU fetch address.
- `ifu_resp_valid`  out  1  one-cycle response pulse to the IFU.
- `ifu_resp_data`  out  DATA_W  fetched word.
- `ifu_resp_err`  out  1  the response is a timeout.
- `lsu_req_valid`  in  1  LSU request.
- `lsu_req_ready`  out  1  LSU request accepted this cycle.
- `lsu_addr`  in  ADDR_W  LSU address.
- `lsu_wen`  in  1  1 = write, 0 = read.
- `lsu_wdata`  in  DATA_W  write data.
- `lsu_wmask`  in  DATA_W/8  byte strobes.
- `lsu_resp_valid`  out  1  one-cycle response pulse to the LSU.
- `lsu_resp_data`  out  DATA_W  read data; 0 for writes.
- `lsu_resp_err`  out  1  the response is a timeout.
- `mem_req_valid`  out  1  request to memory.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_addr`, `mem_wen`, `mem_wdata`, `mem_wmask`  out  registered request payload.
- `mem_resp_valid`  in  1  memory response strobe.
- `mem_resp_data`  in  DATA_W  memory read data.

## Operation
- **States:** IDLE, REQ, RESP.
- **Reset values:**
  - State = IDLE, owner = IFU, last_grant = LSU, counter = 0.
  - All `*_valid`, `*_ready` and `*_err` outputs = 0.
  - All data and address outputs = 0.
- **IDLE:**
  - `*_req_ready` is combinational and asserts only for the winner.
  - If only one requester is valid, it wins.
  - If both are valid, the requester that is not `last_grant` wins.
  - On acceptance:
    - Latch the payload; IFU requests force `wen=0` and `wmask=0`.
    - Set owner and last_grant to the winner.
    - Move to REQ.
- **REQ:**
  - `mem_req_valid=1`, with the payload held stable.
  - When `mem_req_ready=1`: move to RESP and clear the counter.
- **RESP:**
  - The counter increments every cycle.
  - If `mem_resp_valid=1`: register the data to the owner's `resp_data`, pulse the owner's `resp_valid` with `err=0`, and return to IDLE.
  - Else, if counter == `TIMEOUT-1`: pulse the owner's `resp_valid` with `err=1` and `data=0`, and return to IDLE.
  - If `mem_resp_valid` and the timeout condition occur in the same cycle, the real response wins.
- **Stray responses:** `mem_resp_valid` in IDLE or REQ is ignored and dropped.
- **No response backpressure:** requesters must consume a response pulse in the cycle it appears.
- **Late responses:** `TIMEOUT` must exceed the worst-case memory latency. A response arriving after a timeout is undefined behaviour, and a timeout is fatal to the system.
- **Reset mid-operation:** returns to IDLE immediately. No response is issued, and no pending response is remembered.

## Timing
- Accept in cycle N. `mem_req_valid` is high from cycle N+1.
- With `mem_req_ready=1` in N+1, RESP begins in N+2.
- A `mem_resp_valid` in cycle M produces the owner's `resp_valid` in M+1, with the arbiter already in IDLE.
- The next request can therefore be accepted in M+1, the same cycle as the response pulse.
- Best-case round trip: request accepted in N, response pulse in N+3.
- `resp_valid` is asserted for exactly one cycle. Only one of `ifu_resp_valid` / `lsu_resp_valid` is ever high.
- `resp_data` and `resp_err` hold their last values until the next response.
- Timeout: an error pulse appears `TIMEOUT` cycles after RESP is entered.

## Structure
- Package `mem_arb_pkg` holds:
  - the state encoding (IDLE/REQ/RESP, one-hot, 3 bits);
  - the owner encoding (OWN_IFU=0, OWN_LSU=1);
  - the default `TIMEOUT`.
- Sub-module `rr_arb2`: a combinational two-way round-robin grant taking `req[1:0]` and `last_grant`, and producing a one-hot `grant[1:0]`.
- The counter width is `$clog2(TIMEOUT+1)`.

## Test plan
- **IFU-only read:** `ifu_req_valid=1`, addr 0x8000_0000; memory ready at once and responds 1 cycle later with 0x0000_0413 -> `ifu_resp_valid` pulses 3 cycles after acceptance with `data=0x0000_0413` and `err=0`.
- **Simultaneous requests after reset:** IFU and LSU both valid -> IFU is granted first. Holding both valid, the grants then alternate LSU, IFU, LSU.
- **LSU write:** addr 0x8000_0100, `wdata=0xDEADBEEF`, `wmask=4'b0011` -> the `mem_*` payload matches exactly. `mem_req_valid` holds through 3 cycles of `mem_req_ready=0`, and `lsu_resp_valid` pulses once.
- **Timeout:** `TIMEOUT=4`, memory never responds -> `lsu_resp_err=1` with `data=0` exactly 4 cycles after RESP is entered. The next request is accepted normally.
- **Same-cycle tie:** `mem_resp_valid` coincides with counter == `TIMEOUT-1` -> `err=0` and the real data is returned.
- **Reset and strays:**
  - Asserting `rst` low mid-RESP returns every output to 0 asynchronously.
  - A stray `mem_resp_valid` in IDLE produces no response pulse.
